// File: rtl/tristate_bus_port_pkg.sv
// Shared definitions for the tristate bus port: FSM state encoding and the
// width helper used to size the turnaround counter.
package tristate_bus_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TURN_TX = 2'd1,
        ST_TX      = 2'd2,
        ST_TURN_RX = 2'd3
    } port_state_e;

    // Counter holds 0..TURN_CYCLES-1; keep at least one bit so TURN_CYCLES=1 still elaborates.
    function automatic int turn_width(input int turn_cycles);
        return (turn_cycles > 1) ? $clog2(turn_cycles) : 1;
    endfunction

endpackage

// File: rtl/tristate_bus_port_if.sv
// Core-side handshake and peer strobe of the tristate bus port; the pad-level
// inout bus stays a plain port on the top.
interface tristate_bus_port_if #(parameter int WIDTH = 8);

    logic             rx_strobe;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             bus_oe;
    logic             collision;
    logic             err_clr;

    modport slave (
        input  rx_strobe, tx_valid, tx_data, err_clr,
        output rx_data, rx_valid, tx_ready, bus_oe, collision
    );

    modport master (
        output rx_strobe, tx_valid, tx_data, err_clr,
        input  rx_data, rx_valid, tx_ready, bus_oe, collision
    );

endinterface

// File: rtl/tristate_turn_counter.sv
// Down-counter shared by both turnaround gaps: load a start value, decrement
// to zero and hold there.
module tristate_turn_counter #(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/tristate_bus_port.sv
// Half-duplex tristate bus endpoint: receives peer words on strobe rising edges
// and drives local words with released turnaround gaps around every drive burst.
module tristate_bus_port
    import tristate_bus_port_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    inout  wire  [WIDTH-1:0]    bus,
    tristate_bus_port_if.slave  port_if
);

    localparam int            CW        = turn_width(TURN_CYCLES);
    localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYCLES - 1);

    port_state_e      state_q, state_d;
    logic             oe_q, oe_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             collision_q, collision_d;
    logic             strobe_q, strobe_d;
    logic             turn_load, turn_dec, turn_zero;
    logic             strobe_rise;

    tristate_turn_counter #(.CW(CW)) u_turn (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (turn_load),
        .load_val (TURN_LOAD),
        .dec      (turn_dec),
        .zero     (turn_zero)
    );

    assign strobe_rise = port_if.rx_strobe & ~strobe_q;

    always_comb begin
        state_d     = state_q;
        oe_d        = oe_q;
        bus_d       = bus_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        collision_d = collision_q;
        strobe_d    = port_if.rx_strobe;
        turn_load   = 1'b0;
        turn_dec    = 1'b0;

        // A strobe seen while we own or are about to own the bus beats a clear in the same cycle.
        if (port_if.err_clr) begin
            collision_d = 1'b0;
        end
        if (port_if.rx_strobe && (state_q != ST_IDLE)) begin
            collision_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (strobe_rise) begin
                    rx_data_d  = bus;
                    rx_valid_d = 1'b1;
                end else if (port_if.tx_valid) begin
                    state_d   = ST_TURN_TX;
                    turn_load = 1'b1;
                end
            end
            ST_TURN_TX: begin
                if (turn_zero) begin
                    state_d = ST_TX;
                end else begin
                    turn_dec = 1'b1;
                end
            end
            ST_TX: begin
                if (port_if.tx_valid) begin
                    bus_d = port_if.tx_data;
                    oe_d  = 1'b1;
                end else begin
                    oe_d      = 1'b0;
                    state_d   = ST_TURN_RX;
                    turn_load = 1'b1;
                end
            end
            ST_TURN_RX: begin
                if (turn_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                oe_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            oe_q        <= 1'b0;
            bus_q       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            collision_q <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            oe_q        <= oe_d;
            bus_q       <= bus_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            collision_q <= collision_d;
            strobe_q    <= strobe_d;
        end
    end

    assign bus               = oe_q ? bus_q : {WIDTH{1'bz}};
    assign port_if.rx_data   = rx_data_q;
    assign port_if.rx_valid  = rx_valid_q;
    assign port_if.tx_ready  = (state_q == ST_TX);
    assign port_if.bus_oe    = oe_q;
    assign port_if.collision = collision_q;

endmodule
